note_sequencer: RTL

Song-level front end that drives note_player's note-load interface. It reads {note, duration} words from an external synchronous song ROM and presents each note with a one-cycle load pulse. It then waits for the player's done indication before fetching the next word. It stops on an end-of-song marker or after the last slot, and raises song_done.

---
 rtl/note_seq_if.sv | 27 ++
 rtl/note_sequencer.sv | 124 ++++++++++++
 2 files changed

// File: rtl/note_seq_if.sv
// Song ROM and note-player handshake bundle for note_sequencer.
// master = sequencer side; slave = song ROM / player / control side.
interface note_seq_if #(
   parameter int SONG_BITS = 2,
   parameter int NOTE_BITS = 5
);
   logic                           play;
   logic [SONG_BITS-1:0]           song_sel;
   logic [SONG_BITS+NOTE_BITS-1:0] rom_addr;
   logic [11:0]                    rom_data;
   logic [5:0]                     note_to_load;
   logic [5:0]                     duration_to_load;
   logic                           load_new_note;
   logic                           done_with_note;
   logic                           song_done;
   logic [NOTE_BITS-1:0]           note_index;

   modport master (
      input  play, song_sel, rom_data, done_with_note,
      output rom_addr, note_to_load, duration_to_load, load_new_note, song_done, note_index
   );

   modport slave (
      output play, song_sel, rom_data, done_with_note,
      input  rom_addr, note_to_load, duration_to_load, load_new_note, song_done, note_index
   );
endinterface

// File: rtl/note_sequencer.sv
// Walks a song in an external synchronous ROM and feeds note_player one note at a time,
// waiting for the player's done indication between notes; stops on duration 0 or the last slot.
module note_sequencer #(
   parameter int SONG_BITS   = 2,
   parameter int NOTE_BITS   = 5,
   parameter int ROM_LATENCY = 1
) (
   input  logic       clk,
   input  logic       reset,
   note_seq_if.master bus
);
   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] FETCH   = 3'd1;
   localparam logic [2:0] ROMWAIT = 3'd2;
   localparam logic [2:0] LOAD    = 3'd3;
   localparam logic [2:0] ARM     = 3'd4;
   localparam logic [2:0] PLAYING = 3'd5;
   localparam logic [2:0] DONE    = 3'd6;

   localparam logic [1:0]           LAT        = 2'(ROM_LATENCY);
   localparam logic [1:0]           ARM_LIMIT  = 2'd2;
   localparam logic [NOTE_BITS-1:0] LAST_INDEX = '1;
   localparam logic [NOTE_BITS-1:0] ONE_INDEX  = {{(NOTE_BITS-1){1'b0}}, 1'b1};

   logic [2:0]                     state_reg;
   logic [SONG_BITS-1:0]           song_reg;
   logic [NOTE_BITS-1:0]           index_reg;
   logic [NOTE_BITS-1:0]           index_next;
   logic [1:0]                     wait_cnt_reg;
   logic [1:0]                     arm_cnt_reg;
   logic [SONG_BITS+NOTE_BITS-1:0] rom_addr_reg;
   logic [5:0]                     note_reg;
   logic [5:0]                     dur_reg;
   logic [NOTE_BITS-1:0]           note_index_reg;

   assign index_next = index_reg + ONE_INDEX;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg      <= IDLE;
         song_reg       <= '0;
         index_reg      <= '0;
         wait_cnt_reg   <= '0;
         arm_cnt_reg    <= '0;
         rom_addr_reg   <= '0;
         note_reg       <= '0;
         dur_reg        <= '0;
         note_index_reg <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (bus.play) begin
                  song_reg     <= bus.song_sel;
                  index_reg    <= '0;
                  rom_addr_reg <= {bus.song_sel, {NOTE_BITS{1'b0}}};
                  state_reg    <= FETCH;
               end
            end
            FETCH: begin
               if (bus.play) begin
                  wait_cnt_reg <= 2'd1;
                  state_reg    <= ROMWAIT;
               end
            end
            ROMWAIT: begin
               // rom_addr has been stable for LAT cycles once the count matches
               if (bus.play) begin
                  if (wait_cnt_reg == LAT) begin
                     if (bus.rom_data[5:0] == 6'd0) begin
                        state_reg <= DONE;
                     end else begin
                        note_reg       <= bus.rom_data[11:6];
                        dur_reg        <= bus.rom_data[5:0];
                        note_index_reg <= index_reg;
                        state_reg      <= LOAD;
                     end
                  end else begin
                     wait_cnt_reg <= wait_cnt_reg + 2'd1;
                  end
               end
            end
            LOAD: begin
               if (bus.play) begin
                  arm_cnt_reg <= '0;
                  state_reg   <= ARM;
               end
            end
            ARM: begin
               // a player that never drops done is given up on after three ARM cycles
               if (!bus.done_with_note || arm_cnt_reg == ARM_LIMIT) begin
                  state_reg <= PLAYING;
               end else begin
                  arm_cnt_reg <= arm_cnt_reg + 2'd1;
               end
            end
            PLAYING: begin
               if (bus.done_with_note) begin
                  if (index_reg == LAST_INDEX) begin
                     state_reg <= DONE;
                  end else begin
                     index_reg    <= index_next;
                     rom_addr_reg <= {song_reg, index_next};
                     state_reg    <= FETCH;
                  end
               end
            end
            DONE: begin
               if (!bus.play) begin
                  state_reg <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   // Gating with play keeps a paused LOAD from ever emitting its pulse.
   assign bus.load_new_note    = (state_reg == LOAD) && bus.play;
   assign bus.song_done        = (state_reg == DONE);
   assign bus.rom_addr         = rom_addr_reg;
   assign bus.note_to_load     = note_reg;
   assign bus.duration_to_load = dur_reg;
   assign bus.note_index       = note_index_reg;
endmodule
